// File: rtl/per2axi_resp_tracker_pkg.sv
// per2axi response tracker: shared request kinds, entry FSM states and
// the write-response to peripheral-data mapping.
package per2axi_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    ATOP  = 2'd2
  } req_kind_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    AT_RB,
    AT_R,
    AT_B
  } entry_state_e;

  // B resp as peripheral write data: 00->01, 01->00, 10->10, 11->11
  function automatic logic [31:0] wr_resp_map(input logic [1:0] resp);
    return {30'b0, resp[1], resp[1] ~^ resp[0]};
  endfunction

endpackage

// File: rtl/per2axi_resp_tracker_if.sv
// per2axi response tracker bus: request channel, AXI R/B channels and
// the peripheral response / error report side.
interface per2axi_resp_tracker_if
  import per2axi_pkg::*;
#(
  parameter int NB_IDS         = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);

  logic                      req_valid_i;
  logic [1:0]                req_kind_i;
  logic [AXI_ID_WIDTH-1:0]   req_id_i;
  logic [AXI_ADDR_WIDTH-1:0] req_add_i;
  logic                      req_gnt_o;

  logic                      axi_r_valid_i;
  logic                      axi_r_ready_o;
  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i;
  logic [1:0]                axi_r_resp_i;
  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i;

  logic                      axi_b_valid_i;
  logic                      axi_b_ready_o;
  logic [1:0]                axi_b_resp_i;
  logic [AXI_ID_WIDTH-1:0]   axi_b_id_i;

  logic                      per_r_valid_o;
  logic [NB_IDS-1:0]         per_r_id_o;
  logic [31:0]               per_r_rdata_o;
  logic                      per_r_opc_o;

  logic [NB_IDS-1:0]         xresp_valid_o;
  logic [NB_IDS-1:0]         xresp_decerr_o;
  logic [NB_IDS-1:0]         xresp_slverr_o;
  logic                      unexpected_o;

  modport slave (
    input  req_valid_i, req_kind_i, req_id_i, req_add_i,
    output req_gnt_o,
    input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_id_i,
    output axi_r_ready_o,
    input  axi_b_valid_i, axi_b_resp_i, axi_b_id_i,
    output axi_b_ready_o,
    output per_r_valid_o, per_r_id_o, per_r_rdata_o, per_r_opc_o,
    output xresp_valid_o, xresp_decerr_o, xresp_slverr_o, unexpected_o
  );

  modport master (
    output req_valid_i, req_kind_i, req_id_i, req_add_i,
    input  req_gnt_o,
    output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_id_i,
    input  axi_r_ready_o,
    output axi_b_valid_i, axi_b_resp_i, axi_b_id_i,
    input  axi_b_ready_o,
    input  per_r_valid_o, per_r_id_o, per_r_rdata_o, per_r_opc_o,
    input  xresp_valid_o, xresp_decerr_o, xresp_slverr_o, unexpected_o
  );

endinterface

// File: rtl/per2axi_resp_entry.sv
// One tracker entry: follows a single outstanding READ/WRITE/ATOP and
// reports the completing beat (combinationally) to the top-level register.
module per2axi_resp_entry
  import per2axi_pkg::*;
#(
  parameter int OFF_W  = 1,
  parameter int OFF_SW = (OFF_W > 0) ? OFF_W : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req,
  input  logic [1:0]        i_req_kind,
  input  logic [OFF_SW-1:0] i_off,
  input  logic              i_r_hit,
  input  logic [31:0]       i_r_word,
  input  logic [1:0]        i_r_resp,
  input  logic              i_b_hit,
  input  logic [1:0]        i_b_resp,
  output logic              o_idle,
  output logic [OFF_SW-1:0] o_off,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_resp,
  output logic              o_unexpected
);

  entry_state_e r_state;
  logic [31:0]  r_word;
  logic [1:0]   r_rresp;
  logic [1:0]   r_bresp;

  // Entry FSM: a request leaves IDLE, the matching beat(s) bring it back
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_rresp <= '0;
      r_bresp <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            case (i_req_kind)
              READ:    r_state <= RD;
              WRITE:   r_state <= WR;
              ATOP:    r_state <= AT_RB;
              default: r_state <= IDLE;
            endcase
          end
        end
        RD:   if (i_r_hit) r_state <= IDLE;
        WR:   if (i_b_hit) r_state <= IDLE;
        AT_RB: begin
          if (i_r_hit) begin
            r_word  <= i_r_word;
            r_rresp <= i_r_resp;
            r_state <= AT_B;
          end else if (i_b_hit) begin
            r_bresp <= i_b_resp;
            r_state <= AT_R;
          end
        end
        AT_R: if (i_r_hit) r_state <= IDLE;
        AT_B: if (i_b_hit) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    if (OFF_W > 0) begin : g_off
      logic [OFF_SW-1:0] r_off;
      // Lane offset is captured only when the entry accepts a request
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_off <= '0;
        else if (i_req && r_state == IDLE) r_off <= i_off;
      end
      assign o_off = r_off;
    end else begin : g_no_off
      logic w_unused_off;
      assign w_unused_off = ^i_off;
      assign o_off = '0;
    end
  endgenerate

  assign o_idle = (r_state == IDLE);

  // Completion and stray-beat decode for the beat offered this cycle
  always_comb begin
    o_done       = 1'b0;
    o_rdata      = '0;
    o_resp       = '0;
    o_unexpected = 1'b0;
    case (r_state)
      IDLE: o_unexpected = i_r_hit | i_b_hit;
      RD: begin
        o_unexpected = i_b_hit;
        if (i_r_hit) begin
          o_done  = 1'b1;
          o_rdata = i_r_word;
          o_resp  = i_r_resp;
        end
      end
      WR: begin
        o_unexpected = i_r_hit;
        if (i_b_hit) begin
          o_done  = 1'b1;
          o_rdata = wr_resp_map(i_b_resp);
          o_resp  = i_b_resp;
        end
      end
      AT_R: begin
        o_unexpected = i_b_hit;
        if (i_r_hit) begin
          o_done  = 1'b1;
          o_rdata = i_r_word;
          o_resp  = i_r_resp[1] ? i_r_resp : r_bresp;
        end
      end
      AT_B: begin
        o_unexpected = i_r_hit;
        if (i_b_hit) begin
          o_done  = 1'b1;
          o_rdata = r_word;
          o_resp  = r_rresp[1] ? r_rresp : i_b_resp;
        end
      end
      default: o_unexpected = 1'b0;
    endcase
  end

endmodule

// File: rtl/per2axi_resp_tracker.sv
// per2axi response tracker top: R/B arbitration, lane mux, entry array and
// the registered peripheral response. Optional per-ID error report is built
// only when PER2AXI_XRESP_EN is defined.
module per2axi_resp_tracker
  import per2axi_pkg::*;
#(
  parameter int NB_IDS         = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  per2axi_resp_tracker_if.slave bus
);

  localparam int OFF_W    = $clog2(AXI_DATA_WIDTH / 32);
  localparam int OFF_SW   = (OFF_W > 0) ? OFF_W : 1;
  localparam int NB_WORDS = AXI_DATA_WIDTH / 32;

  logic [AXI_ADDR_WIDTH-1:0] w_req_add;
  logic [OFF_SW-1:0]         w_req_off;
  logic                      w_r_fire;
  logic                      w_b_fire;
  logic [OFF_SW-1:0]         w_r_off;
  logic [31:0]               w_r_word;
  logic                      w_gnt;
  logic [31:0]               w_sel_rdata;
  logic [1:0]                w_sel_resp;
  logic                      w_stray;

  logic [OFF_SW-1:0] w_off   [NB_IDS];
  logic [31:0]       w_rdata [NB_IDS];
  logic [1:0]        w_resp  [NB_IDS];
  logic [NB_IDS-1:0] w_idle, w_done, w_unexp, w_req_sel, w_r_hit, w_b_hit;

  logic              r_per_valid;
  logic [NB_IDS-1:0] r_per_id;
  logic [31:0]       r_per_rdata;
  logic              r_per_opc;
  logic              r_unexpected;

  // R is always taken; B only when no R competes in the same cycle
  assign bus.axi_r_ready_o = bus.axi_r_valid_i;
  assign bus.axi_b_ready_o = bus.axi_b_valid_i & ~bus.axi_r_valid_i;
  assign w_r_fire          = bus.axi_r_valid_i;
  assign w_b_fire          = bus.axi_b_valid_i & ~bus.axi_r_valid_i;

  assign w_req_add = bus.req_add_i;

  generate
    if (OFF_W > 0) begin : g_req_off
      logic w_unused_add;
      assign w_unused_add = ^w_req_add;
      assign w_req_off    = w_req_add[OFF_W+1:2];
    end else begin : g_req_no_off
      logic w_unused_add;
      assign w_unused_add = ^w_req_add;
      assign w_req_off    = '0;
    end
  endgenerate

  generate
    for (genvar g = 0; g < NB_IDS; g++) begin : g_entry
      assign w_req_sel[g] = bus.req_valid_i && (bus.req_id_i == AXI_ID_WIDTH'(g));
      assign w_r_hit[g]   = w_r_fire && (bus.axi_r_id_i == AXI_ID_WIDTH'(g));
      assign w_b_hit[g]   = w_b_fire && (bus.axi_b_id_i == AXI_ID_WIDTH'(g));

      per2axi_resp_entry #(
        .OFF_W  (OFF_W),
        .OFF_SW (OFF_SW)
      ) u_entry (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_req        (w_req_sel[g]),
        .i_req_kind   (bus.req_kind_i),
        .i_off        (w_req_off),
        .i_r_hit      (w_r_hit[g]),
        .i_r_word     (w_r_word),
        .i_r_resp     (bus.axi_r_resp_i),
        .i_b_hit      (w_b_hit[g]),
        .i_b_resp     (bus.axi_b_resp_i),
        .o_idle       (w_idle[g]),
        .o_off        (w_off[g]),
        .o_done       (w_done[g]),
        .o_rdata      (w_rdata[g]),
        .o_resp       (w_resp[g]),
        .o_unexpected (w_unexp[g])
      );
    end
  endgenerate

  // Grant reflects whether the addressed entry is currently idle
  always_comb begin
    w_gnt = 1'b0;
    for (int i = 0; i < NB_IDS; i++) begin
      if (bus.req_id_i == AXI_ID_WIDTH'(i)) w_gnt = w_idle[i];
    end
  end
  assign bus.req_gnt_o = w_gnt;

  // Offset of the entry the current R beat belongs to
  always_comb begin
    w_r_off = '0;
    for (int i = 0; i < NB_IDS; i++) begin
      if (bus.axi_r_id_i == AXI_ID_WIDTH'(i)) w_r_off = w_off[i];
    end
  end

  // Pick the 32-bit lane of the R beat selected by that offset
  always_comb begin
    w_r_word = '0;
    for (int k = 0; k < NB_WORDS; k++) begin
      if (w_r_off == OFF_SW'(k)) w_r_word = bus.axi_r_data_i[32*k +: 32];
    end
  end

  // At most one entry completes per cycle, so a priority-free select suffices
  always_comb begin
    w_sel_rdata = '0;
    w_sel_resp  = '0;
    for (int i = 0; i < NB_IDS; i++) begin
      if (w_done[i]) begin
        w_sel_rdata = w_rdata[i];
        w_sel_resp  = w_resp[i];
      end
    end
  end

  assign w_stray = (w_r_fire & ~|w_r_hit) | (w_b_fire & ~|w_b_hit);

  // Register the peripheral response and the stray-beat pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_per_valid  <= 1'b0;
      r_per_id     <= '0;
      r_per_rdata  <= '0;
      r_per_opc    <= 1'b0;
      r_unexpected <= 1'b0;
    end else begin
      r_per_valid  <= |w_done;
      r_per_id     <= w_done;
      r_per_rdata  <= w_sel_rdata;
      r_per_opc    <= |w_done & w_sel_resp[1];
      r_unexpected <= |w_unexp | w_stray;
    end
  end

  assign bus.per_r_valid_o = r_per_valid;
  assign bus.per_r_id_o    = r_per_id;
  assign bus.per_r_rdata_o = r_per_rdata;
  assign bus.per_r_opc_o   = r_per_opc;
  assign bus.unexpected_o  = r_unexpected;

`ifdef PER2AXI_XRESP_EN
  logic [NB_IDS-1:0] r_xresp_valid;
  logic [NB_IDS-1:0] r_xresp_decerr;
  logic [NB_IDS-1:0] r_xresp_slverr;

  // Per-ID error report, one cycle, aligned with the peripheral response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_xresp_valid  <= '0;
      r_xresp_decerr <= '0;
      r_xresp_slverr <= '0;
    end else begin
      r_xresp_valid  <= w_done & {NB_IDS{w_sel_resp[1]}};
      r_xresp_decerr <= w_done & {NB_IDS{w_sel_resp[1] & w_sel_resp[0]}};
      r_xresp_slverr <= w_done & {NB_IDS{w_sel_resp[1] & ~w_sel_resp[0]}};
    end
  end

  assign bus.xresp_valid_o  = r_xresp_valid;
  assign bus.xresp_decerr_o = r_xresp_decerr;
  assign bus.xresp_slverr_o = r_xresp_slverr;
`else
  logic w_unused_resp;
  assign w_unused_resp      = w_sel_resp[0];
  assign bus.xresp_valid_o  = '0;
  assign bus.xresp_decerr_o = '0;
  assign bus.xresp_slverr_o = '0;
`endif

endmodule

// File: tb/tb_per2axi_resp_tracker.sv
// Testbench for per2axi_resp_tracker (128-bit AXI data, 8 IDs): directed
// scenarios followed by randomized traffic against a transaction-level model.
module tb_per2axi_resp_tracker;

  localparam int NB = 8;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  per2axi_resp_tracker_if #(
    .NB_IDS(NB), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(4)
  ) bus ();

  per2axi_resp_tracker #(
    .NB_IDS(NB), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int nCmp  = 0;
  int nFail = 0;

  // Transaction model: kind -1 idle, 0 read, 1 write, 2 atop
  int          mKind  [NB];
  logic [1:0]  mOff   [NB];
  bit          mGotR  [NB];
  bit          mGotB  [NB];
  logic [31:0] mWord  [NB];
  logic [1:0]  mRresp [NB];
  logic [1:0]  mBresp [NB];

  bit          expValid;
  bit          expUnexp;
  int          expId;
  logic [31:0] expRdata;
  logic [1:0]  expResp;
  bit          lastBTaken;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NB; i++) begin
      mKind[i] = -1; mOff[i] = '0; mGotR[i] = 0; mGotB[i] = 0;
      mWord[i] = '0; mRresp[i] = '0; mBresp[i] = '0;
    end
  endtask

  task automatic modelEmit(input int id, input logic [31:0] rdata, input logic [1:0] resp);
    expValid = 1; expId = id; expRdata = rdata; expResp = resp;
    mKind[id] = -1; mGotR[id] = 0; mGotB[id] = 0;
  endtask

  function automatic logic [31:0] writeData(input logic [1:0] resp);
    case (resp)
      2'b00:   return 32'd1;
      2'b01:   return 32'd0;
      2'b10:   return 32'd2;
      default: return 32'd3;
    endcase
  endfunction

  task automatic modelBeat(input bit isR, input int id, input logic [127:0] data, input logic [1:0] resp);
    logic [31:0] w;
    int o;
    o = int'(mOff[id]);
    w = data[32*o +: 32];
    if (mKind[id] < 0) expUnexp = 1;
    else if (isR) begin
      if (mKind[id] == 0) modelEmit(id, w, resp);
      else if (mKind[id] == 1 || mGotR[id]) expUnexp = 1;
      else if (mGotB[id]) modelEmit(id, w, resp[1] ? resp : mBresp[id]);
      else begin mWord[id] = w; mRresp[id] = resp; mGotR[id] = 1; end
    end else begin
      if (mKind[id] == 1) modelEmit(id, writeData(resp), resp);
      else if (mKind[id] == 0 || mGotB[id]) expUnexp = 1;
      else if (mGotR[id]) modelEmit(id, mWord[id], mRresp[id][1] ? mRresp[id] : resp);
      else begin mBresp[id] = resp; mGotB[id] = 1; end
    end
  endtask

  task automatic applyStimulus(input bit reqV, input logic [1:0] kind, input int qid, input logic [31:0] add,
                               input bit rV, input int rid, input logic [127:0] rdata, input logic [1:0] rresp,
                               input bit bV, input int bid, input logic [1:0] bresp);
    bus.req_valid_i   = reqV;
    bus.req_kind_i    = kind;
    bus.req_id_i      = 4'(qid);
    bus.req_add_i     = add;
    bus.axi_r_valid_i = rV;
    bus.axi_r_id_i    = 4'(rid);
    bus.axi_r_data_i  = rdata;
    bus.axi_r_resp_i  = rresp;
    bus.axi_b_valid_i = bV;
    bus.axi_b_id_i    = 4'(bid);
    bus.axi_b_resp_i  = bresp;
  endtask

  task automatic idleStim();
    applyStimulus(0, 2'd0, 0, 32'd0, 0, 0, '0, 2'd0, 0, 0, 2'd0);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.per_r_valid_o), 32'd0);
    checkOutput({tag, "_id"}, 32'(bus.per_r_id_o), 32'd0);
    checkOutput({tag, "_rdata"}, bus.per_r_rdata_o, 32'd0);
    checkOutput({tag, "_opc"}, 32'(bus.per_r_opc_o), 32'd0);
    checkOutput({tag, "_unexp"}, 32'(bus.unexpected_o), 32'd0);
    checkOutput({tag, "_xresp"}, 32'({bus.xresp_valid_o, bus.xresp_decerr_o, bus.xresp_slverr_o}), 32'd0);
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic runCycle();
    bit acc;
    int qid;
    logic [31:0] oneHot;
    #1;
    qid = int'(bus.req_id_i);
    acc = 0;
    if (bus.req_valid_i) begin
      checkOutput("req_gnt", 32'(bus.req_gnt_o), 32'(mKind[qid] < 0));
      acc = (mKind[qid] < 0) && (bus.req_kind_i != 2'd3);
    end
    checkOutput("r_ready", 32'(bus.axi_r_ready_o), 32'(bus.axi_r_valid_i));
    checkOutput("b_ready", 32'(bus.axi_b_ready_o), 32'(bus.axi_b_valid_i & ~bus.axi_r_valid_i));
    expValid = 0; expUnexp = 0; expId = 0; expRdata = '0; expResp = '0;
    lastBTaken = bus.axi_b_valid_i && !bus.axi_r_valid_i;
    if (bus.axi_r_valid_i)
      modelBeat(1, int'(bus.axi_r_id_i), bus.axi_r_data_i, bus.axi_r_resp_i);
    else if (bus.axi_b_valid_i)
      modelBeat(0, int'(bus.axi_b_id_i), '0, bus.axi_b_resp_i);
    if (acc) begin
      mKind[qid] = int'(bus.req_kind_i);
      mOff[qid]  = bus.req_add_i[3:2];
      mGotR[qid] = 0;
      mGotB[qid] = 0;
    end
    @(posedge clk_i);
    #1;
    oneHot = expValid ? (32'd1 << expId) : 32'd0;
    checkOutput("per_r_valid", 32'(bus.per_r_valid_o), 32'(expValid));
    checkOutput("per_r_id", 32'(bus.per_r_id_o), oneHot);
    checkOutput("per_r_rdata", bus.per_r_rdata_o, expValid ? expRdata : 32'd0);
    checkOutput("per_r_opc", 32'(bus.per_r_opc_o), 32'(expValid & expResp[1]));
    checkOutput("unexpected", 32'(bus.unexpected_o), 32'(expUnexp));
`ifdef PER2AXI_XRESP_EN
    checkOutput("xresp_valid", 32'(bus.xresp_valid_o), expResp[1] ? oneHot : 32'd0);
    checkOutput("xresp_decerr", 32'(bus.xresp_decerr_o), (expResp[1] & expResp[0]) ? oneHot : 32'd0);
    checkOutput("xresp_slverr", 32'(bus.xresp_slverr_o), (expResp[1] & ~expResp[0]) ? oneHot : 32'd0);
`else
    checkOutput("xresp_off", 32'({bus.xresp_valid_o, bus.xresp_decerr_o, bus.xresp_slverr_o}), 32'd0);
`endif
  endtask

  function automatic int pickBusy(input int start);
    for (int k = 0; k < NB; k++)
      if (mKind[(start + k) % NB] >= 0) return (start + k) % NB;
    return start;
  endfunction

  initial begin
    bit          rV, bV, bPend, qV;
    int          rid, bid, qid;
    logic [1:0]  rresp, bresp, qkind;
    logic [127:0] rdata;

    // Reset state
    modelReset();
    idleStim();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkZeroOutputs("reset");
    rst_ni = 1'b1;

    // READ id 2, 128-bit lane select from address 0x108
    applyStimulus(1, 2'd0, 2, 32'h108, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'd0, 1, 2, {32'hD, 32'hC, 32'hB, 32'hA}, 2'b00, 0, 0, 2'd0); runCycle();
    checkOutput("tp_read_id", 32'(bus.per_r_id_o), 32'h04);
    checkOutput("tp_read_rdata", bus.per_r_rdata_o, 32'hC);

    // Two WRITEs on id 0 with B resp 01 then 11
    applyStimulus(1, 2'd1, 0, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 0, 0, '0, 2'd0, 1, 0, 2'b01); runCycle();
    checkOutput("tp_wr1_rdata", bus.per_r_rdata_o, 32'h0);
    checkOutput("tp_wr1_opc", 32'(bus.per_r_opc_o), 32'd0);
    applyStimulus(1, 2'd1, 0, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 0, 0, '0, 2'd0, 1, 0, 2'b11); runCycle();
    checkOutput("tp_wr2_rdata", bus.per_r_rdata_o, 32'h3);
    checkOutput("tp_wr2_opc", 32'(bus.per_r_opc_o), 32'd1);
`ifdef PER2AXI_XRESP_EN
    checkOutput("tp_wr2_decerr", 32'(bus.xresp_decerr_o[0]), 32'd1);
`endif

    // ATOP id 5: B first, R three cycles later, single merged response
    applyStimulus(1, 2'd2, 5, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 0, 0, '0, 2'd0, 1, 5, 2'b00); runCycle();
    idleStim(); runCycle();
    idleStim(); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 1, 5, {96'h0, 32'h1234}, 2'b00, 0, 0, 2'd0); runCycle();
    checkOutput("tp_atop_rdata", bus.per_r_rdata_o, 32'h1234);
    checkOutput("tp_atop_valid", 32'(bus.per_r_valid_o), 32'd1);
    idleStim(); runCycle();

    // Simultaneous R id 1 and B id 3: R first, B the next cycle
    applyStimulus(1, 2'd0, 1, 32'h4, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(1, 2'd1, 3, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 1, 1, {32'h4, 32'h3, 32'h2, 32'h1}, 2'b00, 1, 3, 2'b00); runCycle();
    checkOutput("tp_rb_first", 32'(bus.per_r_id_o), 32'h02);
    applyStimulus(0, 2'd0, 0, 32'h0, 0, 0, '0, 2'd0, 1, 3, 2'b00); runCycle();
    checkOutput("tp_rb_second", 32'(bus.per_r_id_o), 32'h08);

    // Stray B on idle entry 4
    applyStimulus(0, 2'd0, 0, 32'h0, 0, 0, '0, 2'd0, 1, 4, 2'b00); runCycle();
    checkOutput("tp_stray_unexp", 32'(bus.unexpected_o), 32'd1);
    idleStim(); runCycle();

    // READ id 6 outstanding, then reset mid-operation
    applyStimulus(1, 2'd0, 6, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0); runCycle();
    applyStimulus(0, 2'd0, 0, 32'h0, 1, 6, '1, 2'b00, 0, 0, 2'd0);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_r_ready", 32'(bus.axi_r_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    checkZeroOutputs("midrst");
    idleStim();
    rst_ni = 1'b1;
    modelReset();
    applyStimulus(1, 2'd0, 6, 32'h0, 0, 0, '0, 2'd0, 0, 0, 2'd0);
    #1;
    checkOutput("tp_rst_gnt6", 32'(bus.req_gnt_o), 32'd1);
    runCycle();

    // Randomized traffic against the model
    bPend = 0; bid = 0; bresp = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      qV    = ($urandom_range(0, 1) == 1);
      qkind = 2'($urandom_range(0, 2));
      qid   = int'($urandom_range(0, NB - 1));
      rV    = ($urandom_range(0, 2) == 0);
      rid   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1))
                                          : pickBusy(int'($urandom_range(0, NB - 1)));
      rdata = {$urandom, $urandom, $urandom, $urandom};
      rresp = 2'($urandom_range(0, 3));
      if (!bPend) begin
        bV    = ($urandom_range(0, 2) == 0);
        bid   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1))
                                            : pickBusy(int'($urandom_range(0, NB - 1)));
        bresp = 2'($urandom_range(0, 3));
      end else begin
        bV = 1;
      end
      applyStimulus(qV, qkind, qid, $urandom, rV, rid, rdata, rresp, bV, bid, bresp);
      runCycle();
      bPend = bV && !lastBTaken;
    end
    idleStim();
    runCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/per2axi_resp_tracker.md
# per2axi_resp_tracker

Parametrised response path of the per2axi bridge. It tracks every outstanding AXI transaction per peripheral ID: read, write or atomic (ATOP). It converts AXI R/B beats into single 32-bit peripheral responses. The AXI data width is generic; the correct 32-bit lane is extracted from the stored request offset. For ATOPs, the R and B responses are merged into one peripheral response. It sits between the per2axi request channel and the peripheral interconnect response port.

## Interface
- NB_IDS, 8: number of peripheral IDs and tracker entries; peripheral IDs are one-hot.
- AXI_ADDR_WIDTH, 32: request address width.
- AXI_DATA_WIDTH, 64: AXI data width; power of two, 32..512.
- AXI_ID_WIDTH, 4: AXI ID width; must satisfy 2^AXI_ID_WIDTH >= NB_IDS.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request channel issued a transaction
- req_kind_i  in  2  0 READ, 1 WRITE, 2 ATOP, 3 reserved
- req_id_i  in  AXI_ID_WIDTH  entry index
- req_add_i  in  AXI_ADDR_WIDTH  request byte address
- req_gnt_o  out  1  entry req_id_i is idle; the request is accepted only when valid and gnt are both high
- axi_r_valid_i / axi_r_ready_o  in / out  1  R handshake
- axi_r_data_i  in  AXI_DATA_WIDTH  read data
- axi_r_resp_i  in  2  R response
- axi_r_id_i  in  AXI_ID_WIDTH  R ID
- axi_b_valid_i / axi_b_ready_o  in / out  1  B handshake
- axi_b_resp_i  in  2  B response
- axi_b_id_i  in  AXI_ID_WIDTH  B ID
- per_r_valid_o  out  1  peripheral response valid, one cycle
- per_r_id_o  out  NB_IDS  one-hot destination
- per_r_rdata_o  out  32  response data
- per_r_opc_o  out  1  1 if the response carries an error
- xresp_valid_o / xresp_decerr_o / xresp_slverr_o  out  NB_IDS  error report, per ID
- unexpected_o  out  1  pulse: a response arrived for an idle entry

## Operation
- Each entry runs its own FSM with states IDLE, RD, WR, AT_RB, AT_R, AT_B.
- Accepted request from IDLE: READ→RD, WRITE→WR, ATOP→AT_RB. The entry stores OFF = req_add_i[OFF_W+1:2], where OFF_W = log2(AXI_DATA_WIDTH/32). When OFF_W = 0, OFF is not stored.
- axi_r_ready_o = axi_r_valid_i: R is always accepted.
- axi_b_ready_o = axi_b_valid_i & ~axi_r_valid_i: R wins a simultaneous arrival, and B stalls one or more cycles.
- Lane select: word = axi_r_data_i[32*OFF +: 32].
- RD + R beat → IDLE. Emits a response with rdata = word.
- WR + B → IDLE. Emits a response with rdata = {30'b0, resp[1], resp[1] ~^ resp[0]}, which maps 00→01, 01→00, 10→10, 11→11.
- AT_RB + R → AT_B. Stores word and R resp; emits nothing.
- AT_RB + B → AT_R. Stores B resp; emits nothing.
- AT_B + B → IDLE, and AT_R + R → IDLE. Each emits one response with rdata = R word and resp = R resp if R resp[1] is set, else B resp.
- R or B beat for an entry in IDLE, or of the wrong kind (e.g. B in RD): the beat is accepted and dropped. unexpected_o pulses; entry state is unchanged.
- Error (resp[1] = 1) on an emitted response: per_r_opc_o = 1. With resp[0] = 1, decerr is reported; otherwise slverr.
- Only single-beat R is supported; axi_r_last_i is not a port.

## Timing
- Response latency: emitted responses are registered, so per_r_* and xresp_* appear the cycle after the completing R/B handshake.
- At most one response per cycle. This holds because at most one R/B handshake completes per cycle.
- req_gnt_o is combinational from the state of entry req_id_i.
- A request and a completion on the same entry in the same cycle: the request is not granted, because the entry is not yet IDLE.
- Reset values: all entries IDLE. per_r_valid_o, per_r_id_o, per_r_rdata_o, per_r_opc_o, xresp_* and unexpected_o are all 0. Stored offsets and data are cleared to 0.
- Reset mid-operation: all tracking is lost and no response is emitted. AXI ready outputs follow valid combinationally even during reset.

## Configuration
- PER2AXI_XRESP_EN defined: xresp_valid_o, xresp_decerr_o and xresp_slverr_o are driven as described above.
- PER2AXI_XRESP_EN undefined: the xresp outputs are tied to 0 and their registers are not built. per_r_opc_o still reports errors.

## Structure
- Package per2axi_pkg holds req_kind_e (READ, WRITE, ATOP), the entry_state_e enum and the write-response mapping function.
- Sub-module per2axi_resp_entry implements one entry: the FSM, the stored OFF, the stored word and the stored resp. It is instantiated NB_IDS times in a generate loop.
- The top level owns the R/B arbitration, the lane mux and the output register.

## Test plan
- READ, AXI_DATA_WIDTH = 128, id 2, add 0x108; R data word3..0 = 0xD,0xC,0xB,0xA, resp 00 → next cycle: per_r_valid_o = 1, per_r_id_o = 0x04, rdata = 0xC, opc = 0.
- WRITE id 0; B resp 01, then a second WRITE with B resp 11 → rdata = 0x0 with opc = 0, then rdata = 0x3 with opc = 1, xresp_decerr_o[0] = 1.
- ATOP id 5; B resp 00 first, R resp 00 with word 0x1234 three cycles later → exactly one response, rdata = 0x1234, issued the cycle after R.
- R id 1 and B id 3 valid in the same cycle → axi_b_ready_o = 0 that cycle. The two responses appear on consecutive cycles, R first.
- B id 4 arriving while entry 4 is IDLE → unexpected_o pulses once, and no per_r_valid_o.
- READ id 6 outstanding, reset asserted → all outputs 0 and req_gnt_o = 1 for id 6 after reset.
